multdiv_stall_controller: RTL
=============================

MULTDIV_STALL_CONTROLLER -- requirements
Module: multdiv_stall_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, meaning the maximum BUSY cycles before a forced exception.
REQ-002 SHALL have parameter CNT_W, default 6, meaning the cycle counter width (2^CNT_W > TIMEOUT).
REQ-003 SHALL have port clock  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port IR_Execute  in  32  instruction in Execute.
REQ-006 SHALL have ports operandA, operandB  in  32 each  bypassed Execute operands.
REQ-007 SHALL have port flush  in  1  abort the in-flight operation.
REQ-008 SHALL have ports md_resultRDY  in  1, md_exception  in  1, md_result  in  32  multdiv unit outputs.
REQ-009 SHALL have ports md_ctrl_MULT, md_ctrl_DIV  out  1 each  start pulses to multdiv.
REQ-010 SHALL have ports md_operandA, md_operandB  out  32 each  latched operands.
REQ-011 SHALL have ports stall  out  1  freeze PC/F/D/X latches; done  out  1  result valid.
REQ-012 SHALL have ports result  out  32, dest_reg  out  5, wren  out  1  writeback payload.

Function
REQ-013 SHALL decode is_md = (IR_Execute[31:27]==00000) & (IR_Execute[6:2]==00110 mul or 00111 div).
REQ-014 SHALL implement FSM states IDLE, START, BUSY, DONE.
REQ-015 IDLE: when is_md & ~flush, SHALL latch operandA/B, op type and rd=IR_Execute[26:22], and go to START.
REQ-016 START: SHALL pulse exactly one of md_ctrl_MULT/md_ctrl_DIV for one cycle, clear the counter, and go to BUSY.
REQ-017 BUSY: SHALL increment the counter each cycle; on md_resultRDY it SHALL capture md_result/md_exception and go to DONE.
REQ-018 BUSY: when the counter reaches TIMEOUT-1 without RDY, SHALL go to DONE with exception forced.
REQ-019 DONE: SHALL hold done=1 and wren=1 for exactly one cycle, then return to IDLE.
REQ-020 stall SHALL be combinational: 1 in IDLE when is_md & ~flush, and 1 in START and BUSY; 0 in DONE.
REQ-021 On normal completion, SHALL set result=md_result and dest_reg=latched rd.
REQ-022 On exception, SHALL set dest_reg=30 and result=4 (mul) or 5 (div).
REQ-023 md_resultRDY and md_exception SHALL be ignored outside BUSY.
REQ-024 If RDY and the timeout coincide, RDY SHALL win.
REQ-025 flush in START or BUSY SHALL return to IDLE next cycle with no done/wren, and SHALL suppress the start pulse in START.
REQ-026 If flush and RDY coincide, flush SHALL win.
REQ-027 A new is_md seen in IDLE the cycle after DONE SHALL start a new operation (back-to-back with no dead cycle).
REQ-028 Latched operands SHALL stay stable on md_operandA/B from START until the state leaves BUSY.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, counter 0, and all registered outputs (md_operandA/B, result, dest_reg, done, wren, start pulses) to 0.
REQ-030 Reset deassertion mid-operation SHALL leave the FSM in IDLE, with no residual done, wren or start pulse.

Structure
REQ-031 A shared package SHALL hold the opcode/ALUop constants, the FSM state encoding, the rstatus codes (4, 5), register index 30, and the TIMEOUT default.
REQ-032 The counter SHALL be a sub-module md_timeout_counter (clear, enable, terminal-count output).

Verification
REQ-033 mul 6*7 detected at cycle T, RDY at T+33 -> start pulse at T+1, stall high T..T+33, done at T+34 with result=42 and dest_reg=rd.
REQ-034 div 9/0 with RDY+md_exception -> done with dest_reg=30, result=5, wren=1.
REQ-035 mul with RDY never asserted -> done after 40 BUSY cycles with dest_reg=30, result=4.
REQ-036 flush at BUSY cycle 10 -> IDLE next cycle, stall 0, no done; a late RDY is ignored.
REQ-037 Two back-to-back muls -> two start pulses, two done pulses, no stall gap between the DONE cycle and the second detect.
REQ-038 reset_n low in BUSY -> all outputs 0 immediately; after release, no done or wren is produced.

Source files
------------

// File: rtl/multdiv_stall_controller_pkg.sv
// Shared constants and types for the multdiv stall controller.
// Holds the instruction decode constants, the FSM state encoding, the
// rstatus exception codes, the rstatus register index and the default
// BUSY timeout.
package multdiv_stall_controller_pkg;

    // Instruction decode fields
    localparam logic [4:0] OpcodeAlu = 5'b00000;
    localparam logic [4:0] AluOpMul  = 5'b00110;
    localparam logic [4:0] AluOpDiv  = 5'b00111;

    // Exception writeback payload
    localparam logic [31:0] RstatusMul = 32'd4;
    localparam logic [31:0] RstatusDiv = 32'd5;
    localparam logic [4:0]  RegRstatus = 5'd30;

    // Maximum BUSY cycles before a forced exception
    localparam int unsigned TimeoutDefault = 40;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StBusy,
        StDone
    } md_state_e;

    typedef enum logic {
        OpMul,
        OpDiv
    } md_op_e;

    // True for an ALU-opcode instruction whose ALUop selects mul or div.
    function automatic logic is_md_instr(input logic [4:0] opcode, input logic [4:0] aluop);
        return (opcode == OpcodeAlu) && ((aluop == AluOpMul) || (aluop == AluOpDiv));
    endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Cycle counter bounding how long the controller waits for the multdiv unit.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset, counter to 0
//   clr_i  - synchronous clear (has priority over enable)
//   en_i   - increment by one this cycle
//   tc_o   - high while the count equals TermCount
module md_timeout_counter #(
    parameter int unsigned Width     = 6,
    parameter int unsigned TermCount = 39
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == Width'(TermCount));

endmodule

// File: rtl/multdiv_stall_controller.sv
// Stall controller sequencing a multi-cycle multiply/divide unit from the
// Execute stage. It latches operands, pulses the unit's start line, freezes
// the pipeline while the unit works and hands back a one-cycle writeback.
// Ports:
//   clock, reset_n               - clock (rising edge), async active-low reset
//   IR_Execute                   - instruction currently in Execute
//   operandA, operandB           - bypassed Execute operands
//   flush                        - abort the in-flight operation
//   md_resultRDY/exception/result- multdiv unit outputs
//   md_ctrl_MULT, md_ctrl_DIV    - one-cycle start pulses to the unit
//   md_operandA, md_operandB     - operands held for the unit
//   stall                        - freeze PC/F/D/X latches (combinational)
//   done, wren, result, dest_reg - writeback payload, valid for one cycle
module multdiv_stall_controller
    import multdiv_stall_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] IR_Execute,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        flush,
    input  logic        md_resultRDY,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  dest_reg,
    output logic        wren
);

    md_state_e   state_d, state_q;
    md_op_e      op_d, op_q;
    logic [4:0]  rd_d, rd_q;
    logic [31:0] opa_d, opa_q;
    logic [31:0] opb_d, opb_q;
    logic        mult_d, mult_q;
    logic        div_d, div_q;
    logic        done_d, done_q;
    logic        wren_d, wren_q;
    logic [31:0] result_d, result_q;
    logic [4:0]  dest_d, dest_q;
    logic        cnt_clr, cnt_en, cnt_tc;
    logic        is_md, is_div;
    logic        unused_ir;

    assign is_md     = is_md_instr(IR_Execute[31:27], IR_Execute[6:2]);
    assign is_div    = (IR_Execute[6:2] == AluOpDiv);
    assign unused_ir = ^{IR_Execute[21:7], IR_Execute[1:0]};

    md_timeout_counter #(
        .Width     (CNT_W),
        .TermCount (TIMEOUT - 1)
    ) u_timeout_counter (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        mult_d   = 1'b0;
        div_d    = 1'b0;
        done_d   = 1'b0;
        wren_d   = 1'b0;
        result_d = result_q;
        dest_d   = dest_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        stall    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (is_md && !flush) begin
                    stall   = 1'b1;
                    op_d    = is_div ? OpDiv : OpMul;
                    rd_d    = IR_Execute[26:22];
                    opa_d   = operandA;
                    opb_d   = operandB;
                    // Start pulse is registered so it is high during START.
                    mult_d  = !is_div;
                    div_d   = is_div;
                    state_d = StStart;
                end
            end
            StStart: begin
                stall   = 1'b1;
                cnt_clr = 1'b1;
                state_d = flush ? StIdle : StBusy;
            end
            StBusy: begin
                stall  = 1'b1;
                cnt_en = 1'b1;
                if (flush) begin
                    state_d = StIdle;
                end else if (md_resultRDY || cnt_tc) begin
                    // RDY outranks a coincident timeout.
                    done_d  = 1'b1;
                    wren_d  = 1'b1;
                    state_d = StDone;
                    if (md_resultRDY && !md_exception) begin
                        result_d = md_result;
                        dest_d   = rd_q;
                    end else begin
                        result_d = (op_q == OpDiv) ? RstatusDiv : RstatusMul;
                        dest_d   = RegRstatus;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            rd_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            mult_q   <= 1'b0;
            div_q    <= 1'b0;
            done_q   <= 1'b0;
            wren_q   <= 1'b0;
            result_q <= '0;
            dest_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            mult_q   <= mult_d;
            div_q    <= div_d;
            done_q   <= done_d;
            wren_q   <= wren_d;
            result_q <= result_d;
            dest_q   <= dest_d;
        end
    end

    // A flush arriving during START must not let the unit start.
    assign md_ctrl_MULT = mult_q & ~flush;
    assign md_ctrl_DIV  = div_q & ~flush;
    assign md_operandA  = opa_q;
    assign md_operandB  = opb_q;
    assign done         = done_q;
    assign wren         = wren_q;
    assign result       = result_q;
    assign dest_reg     = dest_q;

endmodule
